// File: rtl/dcount_timer_if.sv
// Button and display bundle for the two-digit countdown timer.
// The bench drives the buttons through master; the timer uses slave.
interface dcount_timer_if;
  logic       btn_start;
  logic       btn_load;
  logic [7:0] hex0;
  logic [7:0] hex1;
  logic       done;

  modport master (output btn_start, btn_load, input hex0, hex1, done);
  modport slave  (input btn_start, btn_load, output hex0, hex1, done);
endinterface

// File: rtl/dcount_timer.sv
// Two-digit BCD countdown timer with debounced start/pause and reload buttons.
// Defining DCOUNT_TIMER_BLINK_EN makes the display blink while in DONE.
module dcount_timer #(
  parameter int         TICK_DIV = 50000000,
  parameter int         DEB_BITS = 16,
  parameter logic [7:0] PRESET   = 8'h59
) (
  input  logic          clk,
  input  logic          clr,
  dcount_timer_if.slave io
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  function automatic logic [7:0] seg(input logic [3:0] d);
    logic [7:0] s;
    unique case (d)
      4'd0: s = 8'b11000000;
      4'd1: s = 8'b11111001;
      4'd2: s = 8'b10100100;
      4'd3: s = 8'b10110000;
      4'd4: s = 8'b10011001;
      4'd5: s = 8'b10010010;
      4'd6: s = 8'b10000010;
      4'd7: s = 8'b11111000;
      4'd8: s = 8'b10000000;
      4'd9: s = 8'b10011000;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  logic                st_s1_q, st_s1_d, st_s2_q, st_s2_d;
  logic                ld_s1_q, ld_s1_d, ld_s2_q, ld_s2_d;
  logic [DEB_BITS-1:0] deb_cnt_q, deb_cnt_d;
  logic                st_deb_q, st_deb_d, ld_deb_q, ld_deb_d;
  logic                st_pls_q, st_pls_d, ld_pls_q, ld_pls_d;
  state_e              state_q, state_d;
  logic [7:0]          val_q, val_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [7:0]          hex0_q, hex0_d, hex1_q, hex1_d;
  logic                done_q, done_d;
`ifdef DCOUNT_TIMER_BLINK_EN
  logic [23:0]         blink_q, blink_d;
`endif

  // Button path: synchronize, sample on the debounce strobe, pulse on press.
  always_comb begin
    st_s1_d   = io.btn_start;
    st_s2_d   = st_s1_q;
    ld_s1_d   = io.btn_load;
    ld_s2_d   = ld_s1_q;
    deb_cnt_d = deb_cnt_q + DEB_BITS'(1);
    st_deb_d  = st_deb_q;
    ld_deb_d  = ld_deb_q;
    st_pls_d  = 1'b0;
    ld_pls_d  = 1'b0;
    if (&deb_cnt_q) begin
      st_deb_d = st_s2_q;
      ld_deb_d = ld_s2_q;
      st_pls_d = st_deb_q & ~st_s2_q;
      ld_pls_d = ld_deb_q & ~ld_s2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    pre_d   = pre_q;
    if (ld_pls_q) begin
      state_d = IDLE;
      val_d   = PRESET;
      pre_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          pre_d = '0;
          if (st_pls_q) state_d = (PRESET == 8'h00) ? DONE : RUN;
        end
        RUN: begin
          if (st_pls_q) begin
            state_d = PAUSE;
          end else if (pre_q == PRE_MAX) begin
            pre_d = '0;
            if (val_q == 8'h01) begin
              val_d   = 8'h00;
              state_d = DONE;
            end else if (val_q[3:0] == 4'd0) begin
              val_d = {val_q[7:4] - 4'd1, 4'd9};
            end else begin
              val_d = {val_q[7:4], val_q[3:0] - 4'd1};
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        PAUSE: if (st_pls_q) state_d = RUN;
        DONE: begin
          pre_d = '0;
          if (st_pls_q) begin
            state_d = IDLE;
            val_d   = PRESET;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Display registers follow state/value by one clock; value is 00 in DONE.
  always_comb begin
    hex0_d = seg(val_q[3:0]);
    hex1_d = seg(val_q[7:4]);
    done_d = (state_q == DONE);
`ifdef DCOUNT_TIMER_BLINK_EN
    blink_d = blink_q + 24'd1;
    if (state_q == DONE && blink_q[23]) begin
      hex0_d = 8'hFF;
      hex1_d = 8'hFF;
    end
`endif
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st_s1_q   <= 1'b1;
      st_s2_q   <= 1'b1;
      ld_s1_q   <= 1'b1;
      ld_s2_q   <= 1'b1;
      deb_cnt_q <= '0;
      st_deb_q  <= 1'b1;
      ld_deb_q  <= 1'b1;
      st_pls_q  <= 1'b0;
      ld_pls_q  <= 1'b0;
      state_q   <= IDLE;
      val_q     <= PRESET;
      pre_q     <= '0;
      hex0_q    <= seg(PRESET[3:0]);
      hex1_q    <= seg(PRESET[7:4]);
      done_q    <= 1'b0;
`ifdef DCOUNT_TIMER_BLINK_EN
      blink_q   <= '0;
`endif
    end else begin
      st_s1_q   <= st_s1_d;
      st_s2_q   <= st_s2_d;
      ld_s1_q   <= ld_s1_d;
      ld_s2_q   <= ld_s2_d;
      deb_cnt_q <= deb_cnt_d;
      st_deb_q  <= st_deb_d;
      ld_deb_q  <= ld_deb_d;
      st_pls_q  <= st_pls_d;
      ld_pls_q  <= ld_pls_d;
      state_q   <= state_d;
      val_q     <= val_d;
      pre_q     <= pre_d;
      hex0_q    <= hex0_d;
      hex1_q    <= hex1_d;
      done_q    <= done_d;
`ifdef DCOUNT_TIMER_BLINK_EN
      blink_q   <= blink_d;
`endif
    end
  end

  assign io.hex0 = hex0_q;
  assign io.hex1 = hex1_q;
  assign io.done = done_q;
endmodule

// File: tb/tb_dcount_timer.sv
// Scoreboard bench for dcount_timer: a decimal-arithmetic reference model queues the
// expected display each clock, a negedge monitor compares against the DUT.
module tb_dcount_timer;
  localparam int TD         = 4;
  localparam int DEB        = 2;
  localparam int PRESET_DEC = 12;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  dcount_timer_if u_if ();
  dcount_timer_if u_if0 ();

  dcount_timer #(.TICK_DIV(TD), .DEB_BITS(DEB), .PRESET(8'h12)) u_dut (
    .clk(clk), .clr(clr), .io(u_if)
  );
  dcount_timer #(.TICK_DIV(TD), .DEB_BITS(DEB), .PRESET(8'h00)) u_dut0 (
    .clk(clk), .clr(clr), .io(u_if0)
  );

  typedef struct {
    logic [7:0] h1;
    logic [7:0] h0;
    logic       d;
    int         k;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: states 0=idle 1=run 2=pause 3=done; value as a plain integer.
  int   k;
  int   m_st, m_val, m_pre;
  logic m_ps, m_pl, m_ds, m_dl;
  logic hs[int];
  logic hl[int];

  function automatic logic [7:0] seg(input int d);
    case (d)
      0: return 8'b11000000;
      1: return 8'b11111001;
      2: return 8'b10100100;
      3: return 8'b10110000;
      4: return 8'b10011001;
      5: return 8'b10010010;
      6: return 8'b10000010;
      7: return 8'b11111000;
      8: return 8'b10000000;
      9: return 8'b10011000;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic push_disp();
    exp_t e;
    e.h1 = seg(m_val / 10);
    e.h0 = seg(m_val % 10);
    e.d  = (m_st == 3);
    e.k  = k;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    k = 0; m_st = 0; m_val = PRESET_DEC; m_pre = 0;
    m_ps = 1'b0; m_pl = 1'b0; m_ds = 1'b1; m_dl = 1'b1;
    hs.delete(); hl.delete();
  endtask

  task automatic model_edge();
    logic ps, pl, bs, bl;
    push_disp();
    ps = m_ps; pl = m_pl;
    m_ps = 1'b0; m_pl = 1'b0;
    if (k % (1 << DEB) == 0) begin
      bs = hs.exists(k - 2) ? hs[k - 2] : 1'b1;
      bl = hl.exists(k - 2) ? hl[k - 2] : 1'b1;
      m_ps = m_ds & ~bs;
      m_pl = m_dl & ~bl;
      m_ds = bs;
      m_dl = bl;
    end
    if (pl) begin
      m_st = 0; m_val = PRESET_DEC; m_pre = 0;
    end else begin
      case (m_st)
        0: begin
          m_pre = 0;
          if (ps) m_st = (PRESET_DEC == 0) ? 3 : 1;
        end
        1: begin
          if (ps) m_st = 2;
          else if (m_pre == TD - 1) begin
            m_pre = 0;
            m_val = m_val - 1;
            if (m_val == 0) m_st = 3;
          end else m_pre = m_pre + 1;
        end
        2: if (ps) m_st = 1;
        default: begin
          m_pre = 0;
          if (ps) begin m_st = 0; m_val = PRESET_DEC; end
        end
      endcase
    end
  endtask

  task automatic step(input logic bs, input logic bl);
    u_if.btn_start  = bs;
    u_if.btn_load   = bl;
    u_if0.btn_start = bs;
    u_if0.btn_load  = bl;
    @(posedge clk);
    #1;
    if (clr) begin
      model_reset();
      push_disp();
    end else begin
      k = k + 1;
      hs[k] = bs;
      hl[k] = bl;
      model_edge();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b1);
  endtask

  task automatic press(input logic s, input logic l, input int n);
    repeat (n) step(~s, ~l);
  endtask

  task automatic assert_clr();
    @(negedge clk);
    #1;
    clr = 1'b1;
    model_reset();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (u_if.hex1 !== e.h1 || u_if.hex0 !== e.h0 || u_if.done !== e.d) begin
        bad++;
        $display("FAIL display k=%0d got hex1=%b hex0=%b done=%b expected hex1=%b hex0=%b done=%b",
                 e.k, u_if.hex1, u_if.hex0, u_if.done, e.h1, e.h0, e.d);
      end
    end
  end

  initial begin
    u_if.btn_start = 1'b1;  u_if.btn_load = 1'b1;
    u_if0.btn_start = 1'b1; u_if0.btn_load = 1'b1;
    model_reset();
    idle(3);
    clr = 1'b0;
    idle(5);

    // Start, count all the way down, then linger in DONE.
    press(1'b1, 1'b0, 8);
    idle(8);
    total++;
    if (u_if0.done !== 1'b1 || u_if0.hex0 !== 8'hC0 || u_if0.hex1 !== 8'hC0) begin
      bad++;
      $display("FAIL zero_preset got done=%b hex1=%b hex0=%b expected done=1 hex1=11000000 hex0=11000000",
               u_if0.done, u_if0.hex1, u_if0.hex0);
    end
    idle(60);

    // DONE -> IDLE, IDLE -> RUN, pause, resume.
    press(1'b1, 1'b0, 6); idle(10);
    press(1'b1, 1'b0, 6); idle(9);
    press(1'b1, 1'b0, 6); idle(20);
    press(1'b1, 1'b0, 6); idle(15);

    // Start and load together while running.
    press(1'b1, 1'b1, 6); idle(12);

    // Run, then a one-clock glitch placed between sample points.
    press(1'b1, 1'b0, 6); idle(7);
    while ((k + 1) % (1 << DEB) != 0) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    idle(10);

    // Reset pulse mid-run.
    assert_clr();
    idle(2);
    clr = 1'b0;
    idle(6);
    press(1'b1, 1'b0, 6); idle(9);
    press(1'b0, 1'b1, 6); idle(6);

    for (int n = 0; n < 70; n++) begin
      int gap, len, which;
      gap   = $urandom_range(1, 40);
      len   = $urandom_range(1, 9);
      which = $urandom_range(0, 9);
      idle(gap);
      if (which == 0)      press(1'b0, 1'b1, len);
      else if (which == 1) press(1'b1, 1'b1, len);
      else                 press(1'b1, 1'b0, len);
      if (which == 2 && $urandom_range(0, 7) == 0) begin
        assert_clr();
        idle($urandom_range(1, 3));
        clr = 1'b0;
      end
    end
    idle(4);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got pending=%0d expected pending=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dcount_timer.md
DCOUNT_TIMER -- requirements
Module: dcount_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000: clocks per countdown step (>=2).
REQ-002 SHALL have parameter DEB_BITS, default 16: button sample period is 2^DEB_BITS clocks.
REQ-003 SHALL have parameter PRESET, default 8'h59: two-digit BCD start value (tens in [7:4], ones in [3:0]).
REQ-004 SHALL have port clk, input, 1: sole clock; all state on posedge clk.
REQ-005 SHALL have port clr, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port btn_start, input, 1: raw start/pause button, active-low (pressed = 0), asynchronous to clk.
REQ-007 SHALL have port btn_load, input, 1: raw reload button, active-low, asynchronous to clk.
REQ-008 SHALL have port hex0, output, 8: ones-digit 7-segment pattern, active-low, bit7 = decimal point.
REQ-009 SHALL have port hex1, output, 8: tens-digit 7-segment pattern, same encoding.
REQ-010 SHALL have port done, output, 1: high while in DONE.

Function
REQ-011 SHALL pass each button through a 2-flop synchronizer, then sample into a debounce register when a free-running DEB_BITS counter is all-ones.
REQ-012 SHALL generate a one-clock press pulse on the 1->0 transition of each debounced button.
REQ-013 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-014 SHALL, on a start press: go IDLE->RUN, RUN->PAUSE, PAUSE->RUN, and DONE->IDLE with value reloaded to PRESET.
REQ-015 SHALL, on a load press in any state: go to IDLE, reload value to PRESET, and clear the prescaler; load SHALL win over a simultaneous start press.
REQ-016 SHALL, on start from IDLE with PRESET = 8'h00, go directly to DONE.
REQ-017 SHALL run the prescaler 0..TICK_DIV-1 only in RUN, hold it in PAUSE, and clear it in IDLE and DONE.
REQ-018 SHALL assert the step tick when the prescaler = TICK_DIV-1 in RUN; the prescaler wraps to 0 on that clock.
REQ-019 SHALL decrement value in BCD on each tick: ones 0 -> 9 with a tens borrow; ones otherwise -1.
REQ-020 SHALL, on a tick with value = 8'h01, load 8'h00 and enter DONE on the same edge.
REQ-021 SHALL decode each digit 0..9 to patterns 0=11000000, 1=11111001, 2=10100100, 3=10110000, 4=10011001, 5=10010010, 6=10000010, 7=11111000, 8=10000000, 9=10011000.
REQ-022 SHALL drive 8'hFF for any non-BCD digit.
REQ-023 SHALL register hex0, hex1 and done, each one clock after the state or value change.

Reset
REQ-024 SHALL, while clr = 1, hold state = IDLE, value = PRESET, prescaler = 0, debounce registers = 1 (released), and pulses = 0.
REQ-025 SHALL hold hex0/hex1 = decoded PRESET and done = 0 during reset.
REQ-026 SHALL, on clr asserted mid-RUN, abort immediately without completing the step.

Configuration
REQ-027 SHALL, with DCOUNT_TIMER_BLINK_EN defined, drive hex0 = hex1 = 8'hFF in DONE whenever bit 23 of a free-running 24-bit counter is 1, and show "00" otherwise.
REQ-028 SHALL, without DCOUNT_TIMER_BLINK_EN, show steady "00" in DONE and omit the 24-bit counter.

Verification (TICK_DIV=4, DEB_BITS=2, PRESET=8'h12 unless noted)
REQ-029 SHALL cover: release clr -> hex1=11111001, hex0=10100100, done=0.
REQ-030 SHALL cover: start press -> RUN; after 4 clocks hex0 shows 1; after 8 clocks value=10; one tick later value=09 (hex1=11000000, hex0=10011000).
REQ-031 SHALL cover: run to 01, then one more tick -> value 00, done=1 one clock later; further ticks leave value at 00.
REQ-032 SHALL cover: start press in RUN at prescaler=2 -> PAUSE holds value and prescaler; start again -> first tick 2 clocks after resume.
REQ-033 SHALL cover: start and load pressed in the same sample window during RUN -> IDLE, value=12.
REQ-034 SHALL cover: a 1-clock glitch on btn_start between sample points -> no state change; clr pulse mid-RUN -> IDLE, value=12.
